// File: rtl/blake512_round_core.sv
// BLAKE-512 G mixing function: four-word ARX quarter-round with message/constant injection.
// Latency: combinational, no storage.
// Backpressure: none, evaluated every cycle from the caller's operands.
module blake512_G_func (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] c,
  input  logic [63:0] d,
  input  logic [63:0] msg_j,
  input  logic [63:0] msg_k,
  input  logic [63:0] c64_j,
  input  logic [63:0] c64_k,
  output logic [63:0] a_nxt,
  output logic [63:0] b_nxt,
  output logic [63:0] c_nxt,
  output logic [63:0] d_nxt
);
  logic [63:0] a1, c1, dx1, d1, bx1, b1;
  logic [63:0] a2, c2, dx2, d2, bx2, b2;

  // Rotations right by 32, 25, 16, 11
  assign a1  = a + b + (msg_j ^ c64_k);
  assign dx1 = d ^ a1;
  assign d1  = {dx1[31:0], dx1[63:32]};
  assign c1  = c + d1;
  assign bx1 = b ^ c1;
  assign b1  = {bx1[24:0], bx1[63:25]};
  assign a2  = a1 + b1 + (msg_k ^ c64_j);
  assign dx2 = d1 ^ a2;
  assign d2  = {dx2[15:0], dx2[63:16]};
  assign c2  = c1 + d2;
  assign bx2 = b1 ^ c2;
  assign b2  = {bx2[10:0], bx2[63:11]};

  assign a_nxt = a2;
  assign b_nxt = b2;
  assign c_nxt = c2;
  assign d_nxt = d2;
endmodule

// Iterative BLAKE-512 compression: chaining value + 1024-bit block + counter -> new chaining value.
// Latency: accept edge, 2*ROUNDS half-round edges, one finalisation edge; out_valid after that.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no input overlap.
module blake512_round_core #(
  parameter int ROUNDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [511:0]  h_in,
  input  logic [1023:0] m_in,
  input  logic [127:0]  t_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [511:0]  h_out
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] K_LAST = 5'(2 * ROUNDS - 1);

  localparam logic [0:15][63:0] CONST = {
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  // One nibble per permutation entry, entry 0 in the top nibble of each row
  localparam logic [0:9][0:15][3:0] SIGMA = {
    64'h0123456789ABCDEF, 64'hEA489FD61C02B753, 64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
    64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19, 64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
    64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0
  };

  logic [1:0]         state;
  logic [4:0]         k;
  logic [0:15][63:0]  v;
  logic [0:15][63:0]  v_next;
  logic [0:7][63:0]   h;
  logic [0:15][63:0]  m;
  logic [0:7][63:0]   h_fin;
  logic [3:0]         rnd;
  logic [3:0]         srow;
  logic [63:0]        t0, t1;

  logic [3:0]  ia [4];
  logic [3:0]  ib [4];
  logic [3:0]  ic [4];
  logic [3:0]  id [4];
  logic [63:0] ga [4];
  logic [63:0] gb [4];
  logic [63:0] gc [4];
  logic [63:0] gd [4];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign t0   = t_in[63:0];
  assign t1   = t_in[127:64];
  assign rnd  = k[4:1];
  assign srow = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;

  // k[0] selects columns (lane i) or diagonals (lane i rotated by its row)
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LI = 2'(gi);
    logic [3:0] sj, sk;

    assign ia[gi] = {2'b00, LI};
    assign ib[gi] = {2'b01, LI + {1'b0, k[0]}};
    assign ic[gi] = {2'b10, LI + {k[0], 1'b0}};
    assign id[gi] = {2'b11, LI + {k[0], k[0]}};
    assign sj     = SIGMA[srow][{k[0], LI, 1'b0}];
    assign sk     = SIGMA[srow][{k[0], LI, 1'b1}];

    blake512_G_func u_g (
      .a     (v[ia[gi]]),
      .b     (v[ib[gi]]),
      .c     (v[ic[gi]]),
      .d     (v[id[gi]]),
      .msg_j (m[sj]),
      .msg_k (m[sk]),
      .c64_j (CONST[sj]),
      .c64_k (CONST[sk]),
      .a_nxt (ga[gi]),
      .b_nxt (gb[gi]),
      .c_nxt (gc[gi]),
      .d_nxt (gd[gi])
    );
  end

  always_comb begin
    v_next = v;
    for (int i = 0; i < 4; i++) begin
      v_next[ia[i]] = ga[i];
      v_next[ib[i]] = gb[i];
      v_next[ic[i]] = gc[i];
      v_next[id[i]] = gd[i];
    end
  end

  always_comb begin
    h_fin = '0;
    for (int i = 0; i < 8; i++) begin
      h_fin[i] = h[i] ^ v[i] ^ v[i+8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      v     <= '0;
      h     <= '0;
      m     <= '0;
      h_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            h     <= h_in;
            m     <= m_in;
            v     <= {h_in, CONST[0:3], t0 ^ CONST[4], t0 ^ CONST[5], t1 ^ CONST[6], t1 ^ CONST[7]};
            k     <= '0;
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          v <= v_next;
          k <= k + 5'd1;
          if (k == K_LAST) state <= ST_FINAL;
        end
        ST_FINAL: begin
          h_out <= h_fin;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blake512_round_core.sv
// Bench for blake512_round_core: known-answer, backpressure, back-to-back, reset abort,
// counter routing, 14-round build and random blocks against a software compression model.
module tb_blake512_round_core;
  logic          clk = 1'b0;
  logic          rst;
  logic          iv16, ir16, ov16, or16;
  logic          iv14, ir14, ov14, or14;
  logic [511:0]  h_in, ho16, ho14;
  logic [1023:0] m_in;
  logic [127:0]  t_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blake512_round_core #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .h_in(h_in), .m_in(m_in),
    .t_in(t_in), .out_valid(ov16), .out_ready(or16), .h_out(ho16)
  );

  blake512_round_core #(.ROUNDS(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .h_in(h_in), .m_in(m_in),
    .t_in(t_in), .out_valid(ov14), .out_ready(or14), .h_out(ho14)
  );

  localparam logic [63:0] KC [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}
  };

  // The eight G applications of a round: four columns, then four diagonals
  localparam int QA [8] = '{ 0, 1, 2, 3, 0, 1, 2, 3};
  localparam int QB [8] = '{ 4, 5, 6, 7, 5, 6, 7, 4};
  localparam int QC [8] = '{ 8, 9,10,11,10,11, 8, 9};
  localparam int QD [8] = '{12,13,14,15,15,12,13,14};

  localparam logic [511:0] IV = {
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
  };
  localparam logic [511:0] KAT_D = {
    64'h97961587F6D970FA, 64'hBA6D2478045DE6D1, 64'hFABD09B61AE50932, 64'h054D52BC29D31BE4,
    64'hFF9102B9F69E2BBD, 64'hB83BE13D4B9C0609, 64'h1E5FA0B48BD081B6, 64'h34058BE0EC49BEB3
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] blake_ref(input logic [511:0] h, input logic [1023:0] m,
                                             input logic [127:0] t, input int rounds);
    logic [63:0]  v [16];
    logic [63:0]  mw [16];
    logic [63:0]  hw [8];
    logic [511:0] res;
    int s, a, b, c, d, j, kk;
    for (int i = 0; i < 8; i++) hw[i] = h[511-64*i -: 64];
    for (int i = 0; i < 16; i++) mw[i] = m[1023-64*i -: 64];
    for (int i = 0; i < 8; i++) v[i] = hw[i];
    for (int i = 0; i < 4; i++) v[8+i] = KC[i];
    v[12] = t[63:0]   ^ KC[4];
    v[13] = t[63:0]   ^ KC[5];
    v[14] = t[127:64] ^ KC[6];
    v[15] = t[127:64] ^ KC[7];
    for (int r = 0; r < rounds; r++) begin
      s = r % 10;
      for (int g = 0; g < 8; g++) begin
        a = QA[g]; b = QB[g]; c = QC[g]; d = QD[g];
        j = SIG[s][2*g]; kk = SIG[s][2*g+1];
        v[a] = v[a] + v[b] + (mw[j] ^ KC[kk]);
        v[d] = rotr(v[d] ^ v[a], 32);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 25);
        v[a] = v[a] + v[b] + (mw[kk] ^ KC[j]);
        v[d] = rotr(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 11);
      end
    end
    for (int i = 0; i < 8; i++) res[511-64*i -: 64] = hw[i] ^ v[i] ^ v[i+8];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Submits one block to the selected core and returns the digest and acceptance-to-valid edges
  task automatic run_block(input bit sel14, input logic [511:0] h, input logic [1023:0] m,
                           input logic [127:0] t, output logic [511:0] dig, output int lat);
    int n;
    @(negedge clk);
    h_in = h; m_in = m; t_in = t;
    n = 0;
    while (!(sel14 ? ir14 : ir16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sel14) iv14 = 1'b1; else iv16 = 1'b1;
    @(negedge clk);
    iv14 = 1'b0; iv16 = 1'b0;
    lat = 0;
    while (!(sel14 ? ov14 : ov16) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    dig = sel14 ? ho14 : ho16;
  endtask

  logic [1023:0] m_kat, m_r;
  logic [511:0]  d, d1, d2, first, h_r;
  logic [127:0]  t_r;
  int            lat, c;
  bit            saw_ov;

  initial begin
    m_kat = '0;
    m_kat[1023 -: 64]         = 64'h0080000000000000;
    m_kat[1023-64*13 -: 64]   = 64'h0000000000000001;
    m_kat[63:0]               = 64'h0000000000000008;

    rst = 1'b1; iv16 = 1'b0; iv14 = 1'b0; or16 = 1'b1; or14 = 1'b1;
    h_in = '0; m_in = '0; t_in = '0;
    #2;
    chk("reset_handshake", 512'({ir16, ov16, ir14, ov14}), 512'(4'b1010));
    chk("reset_h_out", ho16 | ho14, '0);
    @(negedge clk);
    rst = 1'b0;

    // Known answer, 16 rounds
    run_block(1'b0, IV, m_kat, 128'd8, d, lat);
    chk("kat16_digest", d, KAT_D);
    chk("kat16_model", blake_ref(IV, m_kat, 128'd8, 16), KAT_D);
    chk("kat16_latency", 512'(lat), 512'(33));

    // Backpressure: hold the result, offer a competing block
    or16 = 1'b0;
    run_block(1'b0, IV, m_kat, 128'd8, first, lat);
    chk("bp_digest", first, KAT_D);
    h_in = {16{32'hDEADBEEF}};
    iv16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_h_out_stable", ho16, first);
      chk("bp_valid_ready", 512'({ov16, ir16}), 512'(2'b10));
    end
    iv16 = 1'b0; or16 = 1'b1;
    @(negedge clk);
    chk("bp_release", 512'({ov16, ir16}), 512'(2'b01));

    // Back-to-back with in_valid and out_ready tied high
    h_in = IV; m_in = m_kat; t_in = 128'd8; iv16 = 1'b1;
    @(negedge clk);
    h_in = KAT_D; m_in = '0; t_in = 128'd1024;
    c = 0; d1 = '0;
    while (!ir16 && c < 100) begin
      @(negedge clk);
      c++;
      if (ov16) d1 = ho16;
    end
    chk("b2b_gap", 512'(c + 1), 512'(35));
    chk("b2b_first", d1, KAT_D);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    d2 = ho16;
    chk("b2b_second", d2, blake_ref(KAT_D, '0, 128'd1024, 16));

    // Reset at half-round 17 aborts the block
    @(negedge clk);
    h_in = IV; m_in = m_kat; t_in = 128'd8; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    saw_ov = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (ov16) saw_ov = 1'b1;
    end
    rst = 1'b1;
    #1;
    chk("abort_no_valid", 512'(saw_ov | ov16), '0);
    chk("abort_reset_state", {ho16[509:0], ir16, ov16}, 512'(2'b10));
    @(negedge clk);
    rst = 1'b0;
    run_block(1'b0, IV, m_kat, 128'd8, d, lat);
    chk("abort_resubmit", d, KAT_D);
    chk("abort_resubmit_latency", 512'(lat), 512'(33));

    // Counter split: t1 = 1, t0 = 0
    t_r = {64'd1, 64'd0};
    run_block(1'b0, '0, '0, t_r, d, lat);
    chk("counter_split", d, blake_ref('0, '0, t_r, 16));

    // 14-round build
    run_block(1'b1, IV, m_kat, 128'd8, d, lat);
    chk("r14_digest", d, blake_ref(IV, m_kat, 128'd8, 14));
    chk("r14_latency", 512'(lat), 512'(29));

    // Random blocks on both builds
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) h_r[32*i +: 32] = $urandom;
      for (int i = 0; i < 32; i++) m_r[32*i +: 32] = $urandom;
      for (int i = 0; i < 4; i++) t_r[32*i +: 32] = $urandom;
      run_block(1'b0, h_r, m_r, t_r, d, lat);
      chk("rand16", d, blake_ref(h_r, m_r, t_r, 16));
      run_block(1'b1, h_r, m_r, t_r, d, lat);
      chk("rand14", d, blake_ref(h_r, m_r, t_r, 14));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
